// File: rtl/axi_pkg.sv
// ============================================================================
// Module      : axi_pkg
// Description : Shared AXI definitions for the AR/AW arbiters: channel widths
//               (mirroring the `AXI_* macros), the AR payload struct and the
//               arbiter FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 8
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif

package axi_pkg;

  localparam int AXI_ID_W   = `AXI_ID_BITS;
  localparam int AXI_ADDR_W = `AXI_ADDR_BITS;
  localparam int AXI_LEN_W  = `AXI_LEN_BITS;
  localparam int AXI_SIZE_W = `AXI_SIZE_BITS;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [AXI_LEN_W-1:0]  len;
    logic [AXI_SIZE_W-1:0] size;
    logic [1:0]            burst;
  } ar_payload_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/axi_rr_pick.sv
// ============================================================================
// Module      : axi_rr_pick
// Description : Combinational round-robin picker. Returns the first eligible
//               requester searching upward from i_ptr+1 with wrap-around.
//               Eligible = i_req & ~i_mask.
// Ports       : i_req   - request vector
//               i_ptr   - index of the last served requester
//               i_mask  - requesters excluded from this pick
//               o_gnt   - one-hot winner (zero when none)
//               o_valid - a winner exists
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_rr_pick #(
  parameter int N     = 2,
  parameter int PTR_W = 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  input  logic [N-1:0]     i_mask,
  output logic [N-1:0]     o_gnt,
  output logic             o_valid
);

  logic [N-1:0]   w_elig;
  logic [N-1:0]   w_rot_req;
  logic [N-1:0]   w_rot_gnt;
  logic [PTR_W:0] w_sh;
  logic           w_found;

  assign w_elig = i_req & ~i_mask;
  assign w_sh   = {1'b0, i_ptr} + (PTR_W+1)'(1);

  // Rotate so that requester ptr+1 lands on bit 0; a fixed-priority search
  // on the rotated vector is then the round-robin order.
  assign w_rot_req = N'({w_elig, w_elig} >> w_sh);

  always_comb begin
    w_rot_gnt = '0;
    w_found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (w_rot_req[i] && !w_found) begin
        w_rot_gnt[i] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

  // Undo the rotation: upper half of the doubled, left-shifted vector.
  assign o_gnt   = N'(({w_rot_gnt, w_rot_gnt} << w_sh) >> N);
  assign o_valid = |w_elig;

endmodule

`default_nettype wire

// File: rtl/axi_ar_arbiter.sv
// ============================================================================
// Module      : axi_ar_arbiter
// Description : Round-robin AXI AR-channel arbiter/mux. Merges NUM_M master
//               AR channels onto one slave AR channel, holds the grant until
//               the AR handshake, and prefixes the master index onto ARID.
//               Optional macro AXI_AR_SKID_EN inserts a 2-entry skid slice
//               after the mux (registered outputs, no ARREADY_S->ARREADY_M
//               combinational path).
// Ports       : ACLK, ARESETn (async, active-low)
//               AR*_M     - per-master AR channels (ARREADY_M out)
//               AR*_S     - merged slave AR channel, ARID_S = {idx, ARID}
//               gnt       - one-hot current grant
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_ar_arbiter
  import axi_pkg::*;
#(
  parameter int NUM_M    = 2,
  parameter int IDX_BITS = 4
) (
  input  logic                         ACLK,
  input  logic                         ARESETn,
  input  logic [AXI_ID_W-1:0]          ARID_M    [NUM_M],
  input  logic [AXI_ADDR_W-1:0]        ARADDR_M  [NUM_M],
  input  logic [AXI_LEN_W-1:0]         ARLEN_M   [NUM_M],
  input  logic [AXI_SIZE_W-1:0]        ARSIZE_M  [NUM_M],
  input  logic [1:0]                   ARBURST_M [NUM_M],
  input  logic [NUM_M-1:0]             ARVALID_M,
  output logic [NUM_M-1:0]             ARREADY_M,
  output logic [AXI_ID_W+IDX_BITS-1:0] ARID_S,
  output logic [AXI_ADDR_W-1:0]        ARADDR_S,
  output logic [AXI_LEN_W-1:0]         ARLEN_S,
  output logic [AXI_SIZE_W-1:0]        ARSIZE_S,
  output logic [1:0]                   ARBURST_S,
  output logic                         ARVALID_S,
  input  logic                         ARREADY_S,
  output logic [NUM_M-1:0]             gnt
);

  localparam int PTR_W = $clog2(NUM_M);

  typedef struct packed {
    logic [IDX_BITS-1:0] idx;
    ar_payload_t         pl;
  } slot_t;

  arb_state_e       r_state, w_state_nxt;
  logic [NUM_M-1:0] r_gnt, w_gnt_nxt;
  logic [PTR_W-1:0] r_gidx, w_gidx_nxt;
  logic [PTR_W-1:0] r_rr_ptr, w_rr_ptr_nxt;

  logic             w_busy;
  logic             w_mux_valid;
  logic             w_slice_rdy;
  logic             w_up_hs;
  logic [NUM_M-1:0] w_pick;
  logic             w_pick_vld;
  logic [PTR_W-1:0] w_pick_ptr;
  logic [NUM_M-1:0] w_pick_mask;
  logic [PTR_W-1:0] w_pick_idx;
  slot_t            w_mux;

  assign w_busy      = (r_state == ST_BUSY);
  assign w_mux_valid = w_busy & ARVALID_M[r_gidx];
  assign w_up_hs     = w_mux_valid & w_slice_rdy;
  assign ARREADY_M   = r_gnt & {NUM_M{w_slice_rdy}};
  assign gnt         = r_gnt;

  // While busy the picker only matters on a handshake; searching from the
  // current grant with it masked gives back-to-back re-arbitration.
  assign w_pick_ptr  = w_busy ? r_gidx : r_rr_ptr;
  assign w_pick_mask = w_busy ? r_gnt : '0;

  axi_rr_pick #(
    .N     (NUM_M),
    .PTR_W (PTR_W)
  ) u_pick (
    .i_req   (ARVALID_M),
    .i_ptr   (w_pick_ptr),
    .i_mask  (w_pick_mask),
    .o_gnt   (w_pick),
    .o_valid (w_pick_vld)
  );

  always_comb begin
    w_pick_idx = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (w_pick[i]) w_pick_idx = PTR_W'(i);
    end
  end

  always_comb begin
    w_mux = '0;
    if (w_busy) begin
      w_mux.idx      = IDX_BITS'(r_gidx);
      w_mux.pl.id    = ARID_M[r_gidx];
      w_mux.pl.addr  = ARADDR_M[r_gidx];
      w_mux.pl.len   = ARLEN_M[r_gidx];
      w_mux.pl.size  = ARSIZE_M[r_gidx];
      w_mux.pl.burst = ARBURST_M[r_gidx];
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state  <= ST_IDLE;
      r_gnt    <= '0;
      r_gidx   <= '0;
      r_rr_ptr <= PTR_W'(NUM_M - 1);
    end else begin
      r_state  <= w_state_nxt;
      r_gnt    <= w_gnt_nxt;
      r_gidx   <= w_gidx_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_gnt_nxt    = r_gnt;
    w_gidx_nxt   = r_gidx;
    w_rr_ptr_nxt = r_rr_ptr;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_vld) begin
          w_state_nxt = ST_BUSY;
          w_gnt_nxt   = w_pick;
          w_gidx_nxt  = w_pick_idx;
        end else begin
          w_gnt_nxt   = '0;
        end
      end
      ST_BUSY: begin
        // Grant is only released by a completed handshake.
        if (w_up_hs) begin
          w_rr_ptr_nxt = r_gidx;
          if (w_pick_vld) begin
            w_gnt_nxt  = w_pick;
            w_gidx_nxt = w_pick_idx;
          end else begin
            w_state_nxt = ST_IDLE;
            w_gnt_nxt   = '0;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

`ifdef AXI_AR_SKID_EN
  slot_t      r_slot [2];
  logic       r_wptr;
  logic       r_rptr;
  logic [1:0] r_cnt;
  logic       w_pop;
  slot_t      w_out;

  // Ready depends only on slice occupancy, so ARREADY_S never reaches
  // ARREADY_M combinationally; two entries keep one AR per cycle.
  assign w_slice_rdy = (r_cnt != 2'd2);
  assign w_pop       = (r_cnt != 2'd0) & ARREADY_S;
  assign w_out       = (r_cnt != 2'd0) ? r_slot[r_rptr] : '0;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_slot[0] <= '0;
      r_slot[1] <= '0;
      r_wptr    <= 1'b0;
      r_rptr    <= 1'b0;
      r_cnt     <= 2'd0;
    end else begin
      if (w_up_hs) begin
        r_slot[r_wptr] <= w_mux;
        r_wptr         <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      case ({w_up_hs, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign ARVALID_S = (r_cnt != 2'd0);
  assign ARID_S    = {w_out.idx, w_out.pl.id};
  assign ARADDR_S  = w_out.pl.addr;
  assign ARLEN_S   = w_out.pl.len;
  assign ARSIZE_S  = w_out.pl.size;
  assign ARBURST_S = w_out.pl.burst;
`else
  assign w_slice_rdy = ARREADY_S;
  assign ARVALID_S   = w_mux_valid;
  assign ARID_S      = {w_mux.idx, w_mux.pl.id};
  assign ARADDR_S    = w_mux.pl.addr;
  assign ARLEN_S     = w_mux.pl.len;
  assign ARSIZE_S    = w_mux.pl.size;
  assign ARBURST_S   = w_mux.pl.burst;
`endif

endmodule

`default_nettype wire

// File: tb/tb_axi_ar_arbiter.sv
`default_nettype none

module tb_axi_ar_arbiter;
  import axi_pkg::*;

  localparam int NM = 4;
  localparam int IB = 4;
  localparam int SW = AXI_ID_W + IB;

  logic                  ACLK;
  logic                  ARESETn;
  logic [AXI_ID_W-1:0]   ARID_M    [NM];
  logic [AXI_ADDR_W-1:0] ARADDR_M  [NM];
  logic [AXI_LEN_W-1:0]  ARLEN_M   [NM];
  logic [AXI_SIZE_W-1:0] ARSIZE_M  [NM];
  logic [1:0]            ARBURST_M [NM];
  logic [NM-1:0]         ARVALID_M;
  logic [NM-1:0]         ARREADY_M;
  logic [SW-1:0]         ARID_S;
  logic [AXI_ADDR_W-1:0] ARADDR_S;
  logic [AXI_LEN_W-1:0]  ARLEN_S;
  logic [AXI_SIZE_W-1:0] ARSIZE_S;
  logic [1:0]            ARBURST_S;
  logic                  ARVALID_S;
  logic                  ARREADY_S;
  logic [NM-1:0]         gnt;

  typedef struct packed {
    logic [SW-1:0]         id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [AXI_LEN_W-1:0]  len;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec;
  int   n_err;

  axi_ar_arbiter #(.NUM_M(NM), .IDX_BITS(IB)) dut (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .ARID_M    (ARID_M),
    .ARADDR_M  (ARADDR_M),
    .ARLEN_M   (ARLEN_M),
    .ARSIZE_M  (ARSIZE_M),
    .ARBURST_M (ARBURST_M),
    .ARVALID_M (ARVALID_M),
    .ARREADY_M (ARREADY_M),
    .ARID_S    (ARID_S),
    .ARADDR_S  (ARADDR_S),
    .ARLEN_S   (ARLEN_S),
    .ARSIZE_S  (ARSIZE_S),
    .ARBURST_S (ARBURST_S),
    .ARVALID_S (ARVALID_S),
    .ARREADY_S (ARREADY_S),
    .gnt       (gnt)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  function automatic logic [AXI_ADDR_W-1:0] addr_of(input int m, input int k);
    return AXI_ADDR_W'(32'h1000 * (m + 1) + k * 32'h40);
  endfunction

  function automatic logic [AXI_ID_W-1:0] id_of(input int m, input int k);
    return AXI_ID_W'(3 + 5 * m + k);
  endfunction

  function automatic exp_t exp_of(input int m, input int k);
    exp_t e;
    e.id   = {IB'(m), id_of(m, k)};
    e.addr = addr_of(m, k);
    e.len  = AXI_LEN_W'(m + 1);
    return e;
  endfunction

  task automatic set_payload(input int m, input int k);
    ARID_M[m]    = id_of(m, k);
    ARADDR_M[m]  = addr_of(m, k);
    ARLEN_M[m]   = AXI_LEN_W'(m + 1);
    ARSIZE_M[m]  = AXI_SIZE_W'(2);
    ARBURST_M[m] = 2'b01;
  endtask

  // Scoreboard: every slave-side handshake must match the next expected AR.
  always @(negedge ACLK) begin
    if (ARESETn && ARVALID_S && ARREADY_S) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got id=%h addr=%h, expected no transfer", ARID_S, ARADDR_S);
      end else begin
        mon_e = sb.pop_front();
        if ({ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S} !==
            {mon_e.id, mon_e.addr, mon_e.len, AXI_SIZE_W'(2), 2'b01}) begin
          n_err++;
          $display("FAIL sb_payload: got id=%h addr=%h len=%h size=%h burst=%h, expected id=%h addr=%h len=%h size=2 burst=1",
                   ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, mon_e.id, mon_e.addr, mon_e.len);
        end
      end
    end
  end

  task automatic apply_reset();
    ARESETn   = 1'b0;
    ARVALID_M = '0;
    ARREADY_S = 1'b0;
    sb.delete();
    repeat (2) @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
  endtask

  // Master model: each master issues n[i] ARs, advancing after each
  // handshake; returns the number of clock edges until all were accepted.
  task automatic run_masters(input int n0, input int n1, input int n2, input int n3,
                             input bit toggle, output int cyc);
    int rem [NM];
    int k   [NM];
    bit hs  [NM];
    int left;
    logic [NM-1:0] rdy_before;
    rem = '{n0, n1, n2, n3};
    for (int i = 0; i < NM; i++) begin
      k[i] = 0;
      set_payload(i, 0);
      ARVALID_M[i] = (rem[i] > 0);
    end
    ARREADY_S = 1'b1;
    cyc  = 0;
    left = n0 + n1 + n2 + n3;
    while (left > 0) begin
      @(negedge ACLK);
      for (int i = 0; i < NM; i++) hs[i] = ARVALID_M[i] && ARREADY_M[i];
      @(posedge ACLK);
      #1;
      cyc++;
      for (int i = 0; i < NM; i++) begin
        if (hs[i]) begin
          rem[i]--;
          k[i]++;
          left--;
          if (rem[i] == 0) ARVALID_M[i] = 1'b0;
          else set_payload(i, k[i]);
        end
      end
      if (toggle) begin
        rdy_before = ARREADY_M;
        ARREADY_S  = ~ARREADY_S;
`ifdef AXI_AR_SKID_EN
        #1;
        n_vec++;
        if (ARREADY_M !== rdy_before) begin
          n_err++;
          $display("FAIL skid_ready_indep: ARREADY_M=%b after ARREADY_S flip, expected %b", ARREADY_M, rdy_before);
        end
`endif
      end
      if (cyc > 300) begin
        n_vec++;
        n_err++;
        $display("FAIL run_timeout: %0d ARs outstanding after %0d cycles, expected 0", left, cyc);
        break;
      end
    end
    ARREADY_S = 1'b1;
    for (int w = 0; w < 20 && sb.size() != 0; w++) begin
      @(posedge ACLK);
      #1;
    end
  endtask

  task automatic test_reset();
    int cyc;
    apply_reset();
    @(negedge ACLK);
    n_vec++;
    if ({ARVALID_S, ARREADY_M, gnt} !== '0) begin
      n_err++;
      $display("FAIL reset_ctrl: ARVALID_S=%b ARREADY_M=%b gnt=%b, expected all 0", ARVALID_S, ARREADY_M, gnt);
    end
    n_vec++;
    if ({ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S} !== '0) begin
      n_err++;
      $display("FAIL reset_payload: id=%h addr=%h len=%h, expected 0", ARID_S, ARADDR_S, ARLEN_S);
    end
    @(posedge ACLK);
    #1;
    set_payload(1, 0);
    ARVALID_M = 4'b0010;
    ARREADY_S = 1'b0;
    @(posedge ACLK);
    #1;
    @(negedge ACLK);
    n_vec++;
    if (gnt !== 4'b0010) begin
      n_err++;
      $display("FAIL midreset_gnt: gnt=%b, expected 0010", gnt);
    end
`ifndef AXI_AR_SKID_EN
    n_vec++;
    if (ARVALID_S !== 1'b1) begin
      n_err++;
      $display("FAIL midreset_valid: ARVALID_S=%b, expected 1", ARVALID_S);
    end
`endif
    #1;
    ARREADY_S = 1'b1;
    #1;
    n_vec++;
    if (ARREADY_M !== 4'b0010) begin
      n_err++;
      $display("FAIL midreset_ready: ARREADY_M=%b, expected 0010", ARREADY_M);
    end
    ARESETn = 1'b0;
    #1;
    n_vec++;
    if ({ARVALID_S, ARREADY_M, gnt} !== '0) begin
      n_err++;
      $display("FAIL midreset_async: ARVALID_S=%b ARREADY_M=%b gnt=%b, expected all 0", ARVALID_S, ARREADY_M, gnt);
    end
    ARVALID_M = '0;
    ARREADY_S = 1'b0;
    @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    sb.push_back(exp_of(0, 0));
    sb.push_back(exp_of(1, 0));
    run_masters(1, 1, 0, 0, 1'b0, cyc);
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL postreset_order: %0d ARs not seen, expected 0", sb.size());
    end
  endtask

  task automatic test_single();
    int cyc;
    apply_reset();
    set_payload(0, 0);
    ARVALID_M = 4'b0001;
    ARREADY_S = 1'b1;
    sb.push_back(exp_of(0, 0));
    @(negedge ACLK);
    n_vec++;
    if (ARVALID_S !== 1'b0) begin
      n_err++;
      $display("FAIL single_latency: ARVALID_S=%b in request cycle, expected 0", ARVALID_S);
    end
    @(negedge ACLK);
    n_vec++;
    if ({ARVALID_S, ARID_S, ARADDR_S, ARREADY_M} !== {1'b1, 8'h03, 32'h0000_1000, 4'b0001}) begin
      n_err++;
      $display("FAIL single_grant: valid=%b id=%h addr=%h ready=%b, expected 1 03 00001000 0001",
               ARVALID_S, ARID_S, ARADDR_S, ARREADY_M);
    end
    @(posedge ACLK);
    #1;
    ARVALID_M = '0;
    @(negedge ACLK);
    n_vec++;
    if ({ARVALID_S, ARREADY_M, gnt} !== '0) begin
      n_err++;
      $display("FAIL single_idle: ARVALID_S=%b ARREADY_M=%b gnt=%b, expected all 0", ARVALID_S, ARREADY_M, gnt);
    end
    @(posedge ACLK);
    #1;
    for (int k = 0; k < 3; k++) sb.push_back(exp_of(0, k));
    run_masters(3, 0, 0, 0, 1'b0, cyc);
    n_vec++;
    if (cyc !== 6 || sb.size() != 0) begin
      n_err++;
      $display("FAIL single_rate: %0d cycles, %0d left, expected 6 cycles, 0 left", cyc, sb.size());
    end
  endtask

  task automatic test_alternate();
    int cyc;
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      sb.push_back(exp_of(0, k));
      sb.push_back(exp_of(1, k));
    end
    run_masters(4, 4, 0, 0, 1'b0, cyc);
    n_vec++;
    if (cyc !== 9 || sb.size() != 0) begin
      n_err++;
      $display("FAIL alternate_rate: %0d cycles, %0d left, expected 9 cycles, 0 left", cyc, sb.size());
    end
  endtask

  task automatic test_hold();
    apply_reset();
    sb.push_back(exp_of(1, 0));
    sb.push_back(exp_of(0, 0));
    set_payload(1, 0);
    ARVALID_M = 4'b0010;
    ARREADY_S = 1'b0;
    @(posedge ACLK);
    #1;
    set_payload(0, 0);
    ARVALID_M[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge ACLK);
      n_vec++;
      if ({gnt, ARADDR_S, ARVALID_S, ARREADY_M} !== {4'b0010, addr_of(1, 0), (c != 2), 4'b0000}) begin
        n_err++;
        $display("FAIL hold_c%0d: gnt=%b addr=%h valid=%b ready=%b, expected 0010 %h %b 0000",
                 c, gnt, ARADDR_S, ARVALID_S, ARREADY_M, addr_of(1, 0), (c != 2));
      end
      @(posedge ACLK);
      #1;
      ARVALID_M[1] = (c != 1);
    end
    ARREADY_S = 1'b1;
    @(negedge ACLK);
    n_vec++;
    if (ARREADY_M !== 4'b0010) begin
      n_err++;
      $display("FAIL hold_release: ARREADY_M=%b, expected 0010", ARREADY_M);
    end
    @(posedge ACLK);
    #1;
    ARVALID_M[1] = 1'b0;
    @(negedge ACLK);
    n_vec++;
    if ({gnt, ARREADY_M} !== {4'b0001, 4'b0001}) begin
      n_err++;
      $display("FAIL hold_next: gnt=%b ARREADY_M=%b, expected 0001 0001", gnt, ARREADY_M);
    end
    @(posedge ACLK);
    #1;
    ARVALID_M[0] = 1'b0;
    @(negedge ACLK);
    n_vec++;
    if (gnt !== 4'b0000 || sb.size() != 0) begin
      n_err++;
      $display("FAIL hold_done: gnt=%b left=%0d, expected 0000 0", gnt, sb.size());
    end
  endtask

  task automatic test_four();
    int cyc;
    apply_reset();
    sb.push_back(exp_of(1, 0));
    run_masters(0, 1, 0, 0, 1'b0, cyc);
    sb.push_back(exp_of(3, 0));
    sb.push_back(exp_of(1, 0));
    run_masters(0, 1, 0, 1, 1'b0, cyc);
    n_vec++;
    if (cyc !== 3 || sb.size() != 0) begin
      n_err++;
      $display("FAIL four_rr: %0d cycles, %0d left, expected 3 cycles, 0 left", cyc, sb.size());
    end
  endtask

  task automatic test_skid();
    int cyc;
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      sb.push_back(exp_of(0, k));
      sb.push_back(exp_of(1, k));
    end
    run_masters(6, 6, 0, 0, 1'b1, cyc);
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL skid_stream: %0d ARs not seen, expected 0", sb.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec     = 0;
    n_err     = 0;
    ARESETn   = 1'b0;
    ARVALID_M = '0;
    ARREADY_S = 1'b0;
    for (int i = 0; i < NM; i++) set_payload(i, 0);
    test_reset();
`ifdef AXI_AR_SKID_EN
    test_skid();
`else
    test_single();
    test_alternate();
    test_hold();
    test_four();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/axi_ar_arbiter.md
# axi_ar_arbiter

Parametrised AXI read-address channel arbiter and multiplexer that merges NUM_M master AR channels onto one slave-side AR channel. Performs round-robin arbitration, holds the grant until the AR handshake completes, and prefixes the winning master index onto ARID so the R channel can be routed back. Sits in the AXI interconnect between master-side AR ports and the address decoder / slave AR port.

## Interface
- NUM_M, 2, number of masters (2..16)
- IDX_BITS, 4, master-index prefix width on outgoing ARID; NUM_M <= 2**IDX_BITS
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous, active-low reset
- ARID_M  in  [NUM_M][`AXI_ID_BITS]  per-master ARID
- ARADDR_M  in  [NUM_M][`AXI_ADDR_BITS]  per-master ARADDR
- ARLEN_M  in  [NUM_M][`AXI_LEN_BITS]  per-master ARLEN
- ARSIZE_M  in  [NUM_M][`AXI_SIZE_BITS]  per-master ARSIZE
- ARBURST_M  in  [NUM_M][2]  per-master ARBURST
- ARVALID_M  in  [NUM_M]  per-master ARVALID
- ARREADY_M  out  [NUM_M]  per-master ARREADY
- ARID_S  out  `AXI_ID_BITS+IDX_BITS  {master index, ARID}
- ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S  out  as above  selected payload
- ARVALID_S  out  1  slave-side ARVALID
- ARREADY_S  in  1  slave-side ARREADY
- gnt  out  [NUM_M]  one-hot current grant (debug/observation)

## Operation
- FSM: IDLE, BUSY. Registers: gnt (one-hot), rr_ptr (index of last served master).
- IDLE: if any ARVALID_M, winner = first requester searching from rr_ptr+1 upward with wrap; register gnt, go BUSY. No request: stay IDLE, gnt = 0.
- BUSY: ARVALID_S = ARVALID_M[g]; payload = master g's; ARID_S = {g zero-extended to IDX_BITS, ARID_M[g]}. ARREADY_M[g] = ARREADY_S; all other ARREADY_M = 0.
- Handshake (ARVALID_S && ARREADY_S): rr_ptr <= g; re-arbitrate same cycle over ARVALID_M with bit g masked; any winner -> stay BUSY with new gnt; none -> IDLE.
- Grant never changes in BUSY without a handshake (no retraction). If a master illegally drops ARVALID while granted, ARVALID_S drops; grant held.
- Outside BUSY: ARVALID_S = 0, ARREADY_M = 0, payload outputs = 0.
- Single requester is re-granted after its handshake only via IDLE (one bubble).

## Timing
- Reset: FSM IDLE, gnt = 0, rr_ptr = NUM_M-1 (master 0 wins first), ARVALID_S = 0, ARREADY_M = 0, all payload outputs 0.
- Request to ARVALID_S: 1 cycle (grant registered). Handshake path ARREADY_S -> ARREADY_M combinational.
- Sustained throughput with >=2 active masters: one AR per cycle; single master: one per 2 cycles.
- Reset asserted mid-transfer: immediate return to reset state; in-flight address lost.

## Configuration
- AXI_AR_SKID_EN defined: 2-entry skid register slice after the mux; ARVALID_S/payload driven from flops, ARREADY_M[g] = slice not full (no combinational ARREADY_S -> ARREADY_M path); +1 cycle latency, full throughput preserved; slice empties on reset.
- Undefined: behaviour exactly as in Operation/Timing.

## Structure
- Shared package axi_pkg: AXI width localparams mirroring the `AXI_* macros, ar_payload_t struct (id, addr, len, size, burst), FSM state enum.
- Sub-module axi_rr_pick: combinational round-robin picker (req vector, ptr, mask -> one-hot winner, valid); reused by the AW arbiter.

## Test plan
- Reset, then ARVALID_M = 2'b01, ARID_M[0] = 4'h3, ARADDR 0x1000, ARREADY_S = 1 -> cycle 1 ARVALID_S = 1, ARID_S = 8'h03, ARREADY_M = 2'b01 for one cycle, then IDLE.
- Both masters request continuously, ARREADY_S = 1 -> grants alternate M0, M1, M0, M1, one handshake per cycle; ARID_S prefix alternates 0/1.
- M1 granted, ARREADY_S = 0 for 5 cycles, M0 raises request -> gnt stays 2'b10, payload stable; M0 granted in cycle after handshake.
- NUM_M = 4, requests 4'b1010 with rr_ptr = 1 -> M3 first, then M1; ARID_S prefix 4'h3 then 4'h1.
- ARESETn pulsed low while BUSY with ARREADY_S = 0 -> ARVALID_S, ARREADY_M, gnt = 0 immediately; post-reset M0 wins first.
- With AXI_AR_SKID_EN, ARREADY_S toggled 1/0 every cycle, two masters streaming -> no lost or duplicated addresses, order matches grant order, ARREADY_M independent of same-cycle ARREADY_S.
